counter_cell_scheduler: RTL and testbench

- Services AGC-style involuntary counter increments (PINC/MINC) for N_CNT counter cells in erasable RAM, e.g. TIME2..TIME4 at octal 024 onward.
- Latches request pulses, then asks the core pipeline to stall via a stall_req/stall_ack handshake.
- While the core is stalled, takes the RAM port and does a read-modify-write in 15-bit ones-complement.
- Releases the core when no requests remain pending.

---
 rtl/agc_counter_pkg.sv | 32 +++
 rtl/counter_cell_scheduler_if.sv | 46 ++++
 rtl/oc_incdec.sv | 41 ++++
 rtl/counter_cell_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_counter_cell_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_counter_pkg.sv
// Shared types and constants for the AGC involuntary-counter scheduler.
// Provides the scheduler state encoding, the increment direction, the
// ones-complement boundary values and the RAM write payload struct.
package agc_counter_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } sched_state_t;

  typedef enum logic {
    DIR_PINC = 1'b0,
    DIR_MINC = 1'b1
  } dir_t;

  // 15-bit ones-complement landmarks
  localparam logic [DATA_W-1:0] POS_MAX  = 15'o37777;
  localparam logic [DATA_W-1:0] NEG_MAX  = 15'o40000;
  localparam logic [DATA_W-1:0] NEG_ZERO = 15'o77777;
  localparam logic [DATA_W-1:0] NEG_ONE  = 15'o77776;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

endpackage

// File: rtl/counter_cell_scheduler_if.sv
// Core-stall handshake and erasable-RAM port shared between the counter
// scheduler (master) and the core / RAM mux (slave).
//   stall_req         scheduler asks the core to freeze
//   stall_ack         core frozen; scheduler may own the RAM port
//   ram_sel           scheduler drives the RAM port
//   RAM_read_address  counter address to read
//   RAM_read_data     combinational read data
//   RAM_write_address counter address to write
//   RAM_write_data    updated counter value
//   RAM_write_en      write strobe
interface counter_cell_scheduler_if
  import agc_counter_pkg::*;
;

  logic              stall_req;
  logic              stall_ack;
  logic              ram_sel;
  logic [ADDR_W-1:0] RAM_read_address;
  logic [DATA_W-1:0] RAM_read_data;
  logic [ADDR_W-1:0] RAM_write_address;
  logic [DATA_W-1:0] RAM_write_data;
  logic              RAM_write_en;

  modport master (
    output stall_req,
    output ram_sel,
    output RAM_read_address,
    output RAM_write_address,
    output RAM_write_data,
    output RAM_write_en,
    input  stall_ack,
    input  RAM_read_data
  );

  modport slave (
    input  stall_req,
    input  ram_sel,
    input  RAM_read_address,
    input  RAM_write_address,
    input  RAM_write_data,
    input  RAM_write_en,
    output stall_ack,
    output RAM_read_data
  );

endinterface

// File: rtl/oc_incdec.sv
// Combinational 15-bit ones-complement +1 / -1.
//   value  current counter contents
//   dir    DIR_PINC adds one, DIR_MINC subtracts one
//   result updated counter contents
//   ovf    positive overflow (PINC) or negative overflow (MINC)
module oc_incdec
  import agc_counter_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  dir_t              dir,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  always_comb begin
    result = value;
    ovf    = 1'b0;
    if (dir == DIR_PINC) begin
      if (value == POS_MAX) begin
        result = '0;
        ovf    = 1'b1;
      end else if (value == NEG_ZERO) begin
        // -0 steps straight to +1, skipping +0
        result = DATA_W'(1);
      end else begin
        result = value + DATA_W'(1);
      end
    end else begin
      if (value == NEG_MAX) begin
        result = NEG_ZERO;
        ovf    = 1'b1;
      end else if (value == '0) begin
        // +0 steps straight to -1, skipping -0
        result = NEG_ONE;
      end else begin
        result = value - DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_cell_scheduler.sv
// Involuntary counter scheduler: latches PINC/MINC pulses for N_CNT counter
// cells, stalls the core, and performs ones-complement read-modify-write
// cycles on erasable RAM while the core is frozen.
//   clock     system clock
//   reset     synchronous active-high reset
//   pinc_req  per-counter +1 request pulses
//   minc_req  per-counter -1 request pulses
//   bus       stall handshake and RAM port (master side)
//   overflow  per-counter overflow pulse in the WRITE cycle
//   dropped   pulse: a request collided with an identical pending one
//   busy      work pending or FSM active
module counter_cell_scheduler
  import agc_counter_pkg::*;
#(
  parameter int unsigned       N_CNT     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 15'o24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_CNT-1:0]     pinc_req,
  input  logic [N_CNT-1:0]     minc_req,
  counter_cell_scheduler_if.master bus,
  output logic [N_CNT-1:0]     overflow,
  output logic                 dropped,
  output logic                 busy
);

  localparam int unsigned IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1;

  sched_state_t      state_q, state_d;
  logic [N_CNT-1:0]  pend_p_q, pend_m_q;
  logic [N_CNT-1:0]  pend_p_d, pend_m_d;
  logic              drop_c;

  logic [IDX_W-1:0]  cur_idx_q;
  dir_t              cur_dir_q;
  logic [IDX_W-1:0]  sel_idx_c;
  dir_t              sel_dir_c;
  logic              sel_vld_c;
  logic              cur_live_c;

  logic              stall_req_q;
  logic              ram_sel_q;
  logic [ADDR_W-1:0] rd_addr_q;
  ram_wr_t           wr_q;
  logic              wr_en_q;
  logic [N_CNT-1:0]  ovf_q;
  logic              dropped_q;
  logic              busy_q;

  logic [DATA_W-1:0] inc_result;
  logic              inc_ovf;

  oc_incdec u_incdec (
    .value  (bus.RAM_read_data),
    .dir    (cur_dir_q),
    .result (inc_result),
    .ovf    (inc_ovf)
  );

  // Pending-bit update: service clear, new sets, PINC/MINC cancellation, drops
  always_comb begin
    logic clr_p;
    logic clr_m;
    logic pe_p;
    logic pe_m;
    logic cancel;
    pend_p_d = pend_p_q;
    pend_m_d = pend_m_q;
    drop_c   = 1'b0;
    clr_p    = 1'b0;
    clr_m    = 1'b0;
    pe_p     = 1'b0;
    pe_m     = 1'b0;
    cancel   = 1'b0;
    for (int i = 0; i < N_CNT; i++) begin
      clr_p  = (state_q == WRITE) && (cur_idx_q == IDX_W'(i)) && (cur_dir_q == DIR_PINC);
      clr_m  = (state_q == WRITE) && (cur_idx_q == IDX_W'(i)) && (cur_dir_q == DIR_MINC);
      // a bit being serviced this cycle no longer counts as pending
      pe_p   = pend_p_q[i] & ~clr_p;
      pe_m   = pend_m_q[i] & ~clr_m;
      cancel = (pinc_req[i] & minc_req[i]) |
               (pinc_req[i] & pe_m) |
               (minc_req[i] & pe_p);
      pend_p_d[i] = ~cancel & (pinc_req[i] | pe_p);
      pend_m_d[i] = ~cancel & (minc_req[i] | pe_m);
      if (!cancel && ((pinc_req[i] && pe_p) || (minc_req[i] && pe_m))) begin
        drop_c = 1'b1;
      end
    end
  end

  // Lowest index wins; PINC before MINC on the same index
  always_comb begin
    sel_vld_c = 1'b0;
    sel_idx_c = '0;
    sel_dir_c = DIR_PINC;
    for (int i = N_CNT - 1; i >= 0; i--) begin
      if (pend_p_d[i] || pend_m_d[i]) begin
        sel_vld_c = 1'b1;
        sel_idx_c = IDX_W'(i);
        sel_dir_c = pend_p_d[i] ? DIR_PINC : DIR_MINC;
      end
    end
  end

  // Selected request still alive at the end of READ (not cancelled meanwhile)
  always_comb begin
    cur_live_c = 1'b0;
    for (int i = 0; i < N_CNT; i++) begin
      if (cur_idx_q == IDX_W'(i)) begin
        cur_live_c = (cur_dir_q == DIR_PINC) ? pend_p_d[i] : pend_m_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((|pend_p_q) || (|pend_m_q)) state_d = REQ;
      end
      REQ: begin
        if (!sel_vld_c)     state_d = IDLE;
        else if (bus.stall_ack) state_d = READ;
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (!sel_vld_c)         state_d = IDLE;
        else if (bus.stall_ack) state_d = READ;
        else                    state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending bits and registered outputs (decoded from next state)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_p_q    <= '0;
      pend_m_q    <= '0;
      cur_idx_q   <= '0;
      cur_dir_q   <= DIR_PINC;
      stall_req_q <= 1'b0;
      ram_sel_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_q        <= '0;
      wr_en_q     <= 1'b0;
      ovf_q       <= '0;
      dropped_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_p_q    <= pend_p_d;
      pend_m_q    <= pend_m_d;
      dropped_q   <= drop_c;
      stall_req_q <= (state_d != IDLE);
      ram_sel_q   <= (state_d == READ) || (state_d == WRITE);
      busy_q      <= (|pend_p_d) || (|pend_m_d) || (state_d != IDLE);
      wr_en_q     <= 1'b0;
      ovf_q       <= '0;
      if (state_d == READ) begin
        cur_idx_q <= sel_idx_c;
        cur_dir_q <= sel_dir_c;
        rd_addr_q <= BASE_ADDR + ADDR_W'(sel_idx_c);
      end
      if (state_q == READ) begin
        wr_q.addr <= rd_addr_q;
        wr_q.data <= inc_result;
        wr_en_q   <= cur_live_c;
        ovf_q     <= (inc_ovf && cur_live_c) ? (N_CNT'(1) << cur_idx_q) : '0;
      end
    end
  end

  assign bus.stall_req         = stall_req_q;
  assign bus.ram_sel           = ram_sel_q;
  assign bus.RAM_read_address  = rd_addr_q;
  assign bus.RAM_write_address = wr_q.addr;
  assign bus.RAM_write_data    = wr_q.data;
  assign bus.RAM_write_en      = wr_en_q;
  assign overflow              = ovf_q;
  assign dropped               = dropped_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_counter_cell_scheduler.sv
// Directed self-checking bench for counter_cell_scheduler with a small RAM model.
module tb_counter_cell_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] pinc_req;
  logic [3:0] minc_req;
  logic [3:0] overflow;
  logic       dropped;
  logic       busy;

  logic        pre_en;
  logic [5:0]  pre_addr;
  logic [14:0] pre_data;
  logic [14:0] mem [0:63];
  int          wr_count = 0;
  logic [14:0] last_wdata;

  int tests  = 0;
  int failed = 0;

  counter_cell_scheduler_if bus ();

  counter_cell_scheduler #(.N_CNT(4), .BASE_ADDR(15'o24)) dut (
    .clock    (clock),
    .reset    (reset),
    .pinc_req (pinc_req),
    .minc_req (minc_req),
    .bus      (bus),
    .overflow (overflow),
    .dropped  (dropped),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.RAM_read_data = mem[bus.RAM_read_address[5:0]];

  always @(posedge clock) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.RAM_write_en) begin
      mem[bus.RAM_write_address[5:0]] <= bus.RAM_write_data;
      wr_count   <= wr_count + 1;
      last_wdata <= bus.RAM_write_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [14:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (bus.stall_req !== 1'b0) begin failed++; $display("FAIL reset_stall_req: got %b expected 0", bus.stall_req); end
    tests++; if (bus.ram_sel !== 1'b0) begin failed++; $display("FAIL reset_ram_sel: got %b expected 0", bus.ram_sel); end
    tests++; if (bus.RAM_write_en !== 1'b0) begin failed++; $display("FAIL reset_wen: got %b expected 0", bus.RAM_write_en); end
    tests++; if ({overflow, dropped, busy} !== 6'b0) begin failed++; $display("FAIL reset_flags: got %b expected 000000", {overflow, dropped, busy}); end
    tests++; if (bus.RAM_read_address !== 15'o0 || bus.RAM_write_address !== 15'o0) begin
      failed++; $display("FAIL reset_addr: got rd %o wr %o expected 0 0", bus.RAM_read_address, bus.RAM_write_address);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pinc();
    preload(6'o25, 15'o00005);
    pinc_req = 4'b0010;
    tick();                       // cycle 1
    pinc_req = 4'b0000;
    tests++; if (bus.stall_req !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL single_c1: got stall %b busy %b expected 0 1", bus.stall_req, busy); end
    tick();                       // cycle 2: REQ
    tests++; if (bus.stall_req !== 1'b1 || bus.ram_sel !== 1'b0) begin failed++; $display("FAIL single_c2: got stall %b sel %b expected 1 0", bus.stall_req, bus.ram_sel); end
    tick();                       // cycle 3: READ
    tests++; if (bus.ram_sel !== 1'b1 || bus.RAM_read_address !== 15'o25 || bus.RAM_write_en !== 1'b0) begin
      failed++; $display("FAIL single_c3: got sel %b rd %o wen %b expected 1 25 0", bus.ram_sel, bus.RAM_read_address, bus.RAM_write_en);
    end
    tick();                       // cycle 4: WRITE
    tests++; if (bus.RAM_write_en !== 1'b1 || bus.RAM_write_address !== 15'o25 || bus.RAM_write_data !== 15'o6) begin
      failed++; $display("FAIL single_c4_write: got wen %b addr %o data %o expected 1 25 6", bus.RAM_write_en, bus.RAM_write_address, bus.RAM_write_data);
    end
    tests++; if (overflow !== 4'b0 || bus.stall_req !== 1'b1) begin failed++; $display("FAIL single_c4_flags: got ovf %b stall %b expected 0000 1", overflow, bus.stall_req); end
    tick();                       // cycle 5
    tests++; if (bus.stall_req !== 1'b0 || bus.RAM_write_en !== 1'b0 || bus.ram_sel !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL single_c5: got stall %b wen %b sel %b busy %b expected 0 0 0 0", bus.stall_req, bus.RAM_write_en, bus.ram_sel, busy);
    end
  endtask

  task automatic run_one(input int idx, input logic is_minc, input logic [14:0] init,
                         input logic [14:0] exp_data, input logic [3:0] exp_ovf);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    preload(6'(6'o24 + idx), init);
    if (is_minc) minc_req = onehot; else pinc_req = onehot;
    tick();
    pinc_req = 4'b0; minc_req = 4'b0;
    tick(); tick(); tick();       // cycle 4: WRITE
    tests++; if (bus.RAM_write_en !== 1'b1 || bus.RAM_write_address !== 15'(15'o24 + idx) || bus.RAM_write_data !== exp_data) begin
      failed++; $display("FAIL incdec_write idx %0d minc %b init %o: got wen %b addr %o data %o expected data %o",
                         idx, is_minc, init, bus.RAM_write_en, bus.RAM_write_address, bus.RAM_write_data, exp_data);
    end
    tests++; if (overflow !== exp_ovf) begin failed++; $display("FAIL incdec_ovf init %o: got %b expected %b", init, overflow, exp_ovf); end
    tick();
    tests++; if (overflow !== 4'b0 || bus.RAM_write_en !== 1'b0) begin failed++; $display("FAIL incdec_after: got ovf %b wen %b expected 0000 0", overflow, bus.RAM_write_en); end
  endtask

  task automatic test_incdec();
    run_one(0, 1'b0, 15'o37777, 15'o00000, 4'b0001);
    run_one(2, 1'b1, 15'o00000, 15'o77776, 4'b0000);
    run_one(3, 1'b0, 15'o77777, 15'o00001, 4'b0000);
    run_one(1, 1'b1, 15'o40000, 15'o77777, 4'b0010);
    run_one(2, 1'b0, 15'o12345, 15'o12346, 4'b0000);
    run_one(0, 1'b1, 15'o00001, 15'o00000, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp_addr [3];
    logic [14:0] exp_data [3];
    int k;
    exp_addr[0] = 15'o24; exp_addr[1] = 15'o25; exp_addr[2] = 15'o27;
    exp_data[0] = 15'o11; exp_data[1] = 15'o21; exp_data[2] = 15'o31;
    preload(6'o24, 15'o10);
    preload(6'o25, 15'o20);
    preload(6'o27, 15'o30);
    pinc_req = 4'b1011;
    tick();
    pinc_req = 4'b0000;
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      logic e_stall, e_sel, e_wen;
      e_stall = (c >= 2 && c <= 8);
      e_sel   = (c >= 3 && c <= 8);
      e_wen   = (c == 4 || c == 6 || c == 8);
      tests++; if ({bus.stall_req, bus.ram_sel, bus.RAM_write_en} !== {e_stall, e_sel, e_wen}) begin
        failed++; $display("FAIL b2b_ctrl cycle %0d: got stall/sel/wen %b expected %b", c,
                           {bus.stall_req, bus.ram_sel, bus.RAM_write_en}, {e_stall, e_sel, e_wen});
      end
      if (e_wen) begin
        tests++; if (bus.RAM_write_address !== exp_addr[k] || bus.RAM_write_data !== exp_data[k]) begin
          failed++; $display("FAIL b2b_write %0d: got addr %o data %o expected %o %o", k,
                             bus.RAM_write_address, bus.RAM_write_data, exp_addr[k], exp_data[k]);
        end
        k++;
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    bus.stall_ack = 1'b0;
    preload(6'o27, 15'o100);
    pinc_req = 4'b1000;
    tick();
    pinc_req = 4'b0000;
    tick();                       // cycle 2: REQ
    for (int c = 0; c < 10; c++) begin
      tests++; if (bus.stall_req !== 1'b1 || bus.ram_sel !== 1'b0 || bus.RAM_write_en !== 1'b0) begin
        failed++; $display("FAIL hold_req wait %0d: got stall %b sel %b wen %b expected 1 0 0", c, bus.stall_req, bus.ram_sel, bus.RAM_write_en);
      end
      tick();
    end
    bus.stall_ack = 1'b1;
    tick();                       // READ
    tests++; if (bus.ram_sel !== 1'b1 || bus.RAM_read_address !== 15'o27) begin
      failed++; $display("FAIL hold_read: got sel %b rd %o expected 1 27", bus.ram_sel, bus.RAM_read_address);
    end
    tick();                       // WRITE
    tests++; if (bus.RAM_write_en !== 1'b1 || bus.RAM_write_data !== 15'o101) begin
      failed++; $display("FAIL hold_write: got wen %b data %o expected 1 101", bus.RAM_write_en, bus.RAM_write_data);
    end
    tick();
  endtask

  task automatic test_cancel();
    int wc;
    tick();
    wc = wr_count;
    pinc_req = 4'b0100; minc_req = 4'b0100;
    tick();
    pinc_req = 4'b0; minc_req = 4'b0;
    tests++; if (busy !== 1'b0 || bus.stall_req !== 1'b0 || dropped !== 1'b0) begin
      failed++; $display("FAIL cancel_same: got busy %b stall %b dropped %b expected 0 0 0", busy, bus.stall_req, dropped);
    end
    pinc_req = 4'b0001;
    tick();
    pinc_req = 4'b0000; minc_req = 4'b0001;
    tick();
    minc_req = 4'b0000;
    tests++; if (dropped !== 1'b0) begin failed++; $display("FAIL cancel_opp_dropped: got %b expected 0", dropped); end
    for (int c = 0; c < 5; c++) tick();
    tests++; if (wr_count !== wc || busy !== 1'b0) begin
      failed++; $display("FAIL cancel_nowrite: got writes %0d busy %b expected %0d 0", wr_count, busy, wc);
    end
  endtask

  task automatic test_dropped();
    int wc;
    preload(6'o25, 15'o7);
    wc = wr_count;
    pinc_req = 4'b0010;
    tick();                       // cycle 1: repeat pulse while pending
    tests++; if (dropped !== 1'b0) begin failed++; $display("FAIL drop_c1: got %b expected 0", dropped); end
    tick();                       // cycle 2
    pinc_req = 4'b0000;
    tests++; if (dropped !== 1'b1) begin failed++; $display("FAIL drop_c2: got %b expected 1", dropped); end
    tick();
    tests++; if (dropped !== 1'b0) begin failed++; $display("FAIL drop_c3: got %b expected 0", dropped); end
    for (int c = 0; c < 6; c++) tick();
    tests++; if (wr_count !== wc + 1 || last_wdata !== 15'o10) begin
      failed++; $display("FAIL drop_writes: got count %0d data %o expected %0d 10", wr_count - wc, last_wdata, 1);
    end
  endtask

  task automatic test_reset_mid();
    int wc;
    preload(6'o25, 15'o3);
    wc = wr_count;
    pinc_req = 4'b0010;
    tick();
    pinc_req = 4'b0000;
    tick();
    tick();                       // cycle 3: READ
    tests++; if (bus.ram_sel !== 1'b1) begin failed++; $display("FAIL rstmid_read: got sel %b expected 1", bus.ram_sel); end
    reset = 1'b1;
    tick();
    tests++; if ({bus.stall_req, bus.ram_sel, bus.RAM_write_en, busy} !== 4'b0000) begin
      failed++; $display("FAIL rstmid_outputs: got stall/sel/wen/busy %b expected 0000", {bus.stall_req, bus.ram_sel, bus.RAM_write_en, busy});
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    tests++; if (wr_count !== wc) begin failed++; $display("FAIL rstmid_nowrite: got %0d writes expected 0", wr_count - wc); end
  endtask

  initial begin
    reset         = 1'b1;
    pinc_req      = 4'b0;
    minc_req      = 4'b0;
    pre_en        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    bus.stall_ack = 1'b1;
    test_reset();
    test_single_pinc();
    test_incdec();
    test_back_to_back();
    test_stall_hold();
    test_cancel();
    test_dropped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
